// File: rtl/psi_pkg.sv
// Shared constants and default lookup contents for the psi(x) evaluator.
// Magnitudes are fixed point with 2 integer bits.
package psi_pkg;

    localparam int MIN_WIDTH = 5;
    localparam int MAX_WIDTH = 8;

    // round(16 * -ln(tanh(x/2))), x = addr/16; end points pinned to max/0
    localparam logic [5:0] PSI6 [64] = '{
        6'd63, 6'd55, 6'd44, 6'd38, 6'd33, 6'd30, 6'd27, 6'd25,
        6'd23, 6'd21, 6'd19, 6'd18, 6'd16, 6'd15, 6'd14, 6'd13,
        6'd12, 6'd12, 6'd11, 6'd10, 6'd9,  6'd9,  6'd8,  6'd8,
        6'd7,  6'd7,  6'd6,  6'd6,  6'd6,  6'd5,  6'd5,  6'd5,
        6'd4,  6'd4,  6'd4,  6'd4,  6'd3,  6'd3,  6'd3,  6'd3,
        6'd3,  6'd2,  6'd2,  6'd2,  6'd2,  6'd2,  6'd2,  6'd2,
        6'd2,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1,
        6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd1,  6'd0
    };

    function automatic logic [7:0] psi_default(
        input int width,
        input int addr
    );
        int top;
        int sh;
        int idx;
        int frac;
        int nxt;
        int v;
        top = (1 << width) - 1;
        if (addr == 0) begin
            return 8'(top);
        end
        if (addr >= top) begin
            return 8'd0;
        end
        if (width == 6) begin
            return {2'b00, PSI6[addr]};
        end
        if (width < 6) begin
            // Half the resolution: sample every other entry and rescale
            v = (int'(PSI6[2 * addr]) + 1) >> 1;
        end else begin
            // Finer widths interpolate linearly between canonical entries
            sh   = width - 6;
            idx  = addr >> sh;
            frac = addr & ((1 << sh) - 1);
            nxt  = (idx == 63) ? 0 : int'(PSI6[idx + 1]);
            v    = int'(PSI6[idx]) * ((1 << sh) - frac) + nxt * frac;
        end
        if (v > top) begin
            v = top;
        end
        return 8'(v);
    endfunction

endpackage

// File: rtl/psi_table.sv
// Run-time programmable psi lookup table, one write port and
// LANES asynchronous read ports; reset and restore load defaults.
module psi_table
    import psi_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [WIDTH-1:0]         waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     restore,
    input  logic [LANES*WIDTH-1:0]   rd_addr,
    output logic [LANES*WIDTH-1:0]   rd_data
);

    localparam int DEPTH = 1 << WIDTH;

    function automatic logic [DEPTH*WIDTH-1:0] def_flat();
        logic [DEPTH*WIDTH-1:0] r;
        r = '0;
        for (int a = 0; a < DEPTH; a++) begin
            r[a*WIDTH +: WIDTH] = WIDTH'(psi_default(WIDTH, a));
        end
        return r;
    endfunction

    localparam logic [DEPTH*WIDTH-1:0] DEF_FLAT = def_flat();

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            mem_d[a] = mem_q[a];
            if (restore) begin
                mem_d[a] = DEF_FLAT[a*WIDTH +: WIDTH];
            end else if (we && (waddr == WIDTH'(a))) begin
                mem_d[a] = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= DEF_FLAT[a*WIDTH +: WIDTH];
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_q[a] <= mem_d[a];
            end
        end
    end

    // Reads see the registered contents, so a same-edge write is not visible
    always_comb begin
        rd_data = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_data[l*WIDTH +: WIDTH] = mem_q[rd_addr[l*WIDTH +: WIDTH]];
        end
    end

endmodule

// File: rtl/psi_pipe.sv
// Two-stage multi-lane psi(x) evaluator for sign-magnitude LLRs with
// valid/ready flow control and a saturating saturation counter.
module psi_pipe
    import psi_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_sign,
    input  logic [LANES*WIDTH-1:0]   in_mag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_sign,
    output logic [LANES*WIDTH-1:0]   out_mag,
    input  logic                     cfg_we,
    input  logic [WIDTH-1:0]         cfg_addr,
    input  logic [WIDTH-1:0]         cfg_data,
    input  logic                     cfg_restore,
    output logic [CNT_W-1:0]         sat_cnt,
    input  logic                     sat_clr
);

    localparam int INC_W = $clog2(LANES + 1);

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "psi_pipe: WIDTH must be within 5..8");
    end

    logic                   s0_valid_q, s0_valid_d;
    logic [LANES-1:0]       s0_sign_q, s0_sign_d;
    logic [LANES*WIDTH-1:0] s0_mag_q, s0_mag_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [LANES-1:0]       s1_sign_q, s1_sign_d;
    logic [LANES*WIDTH-1:0] s1_mag_q, s1_mag_d;
    logic [CNT_W-1:0]       sat_cnt_q, sat_cnt_d;

    logic [LANES*WIDTH-1:0] lut_data;
    logic                   s0_free;
    logic                   s1_free;
    logic                   out_fire;
    logic [INC_W-1:0]       sat_inc;
    logic [CNT_W:0]         sat_sum;

    psi_table #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .restore (cfg_restore),
        .rd_addr (s0_mag_q),
        .rd_data (lut_data)
    );

    assign s1_free  = !s1_valid_q || out_ready;
    assign s0_free  = !s0_valid_q || s1_free;
    assign in_ready = s0_free;
    assign out_fire = s1_valid_q && out_ready;

    assign out_valid = s1_valid_q;
    assign out_sign  = s1_sign_q;
    assign out_mag   = s1_mag_q;
    assign sat_cnt   = sat_cnt_q;

    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_sign_d  = s0_sign_q;
        s0_mag_d   = s0_mag_q;
        if (s0_free) begin
            s0_valid_d = in_valid;
            if (in_valid) begin
                s0_sign_d = in_sign;
                s0_mag_d  = in_mag;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        if (s1_free) begin
            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_sign_d = s0_sign_q;
                s1_mag_d  = lut_data;
            end
        end
    end

    always_comb begin
        sat_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            if (s1_mag_q[l*WIDTH +: WIDTH] == {WIDTH{1'b1}}) begin
                sat_inc = sat_inc + INC_W'(1);
            end
        end
    end

    // One spare carry bit detects overflow so the count sticks at max
    always_comb begin
        sat_sum   = {1'b0, sat_cnt_q}
                  + {{(CNT_W + 1 - INC_W){1'b0}}, sat_inc};
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_fire) begin
            sat_cnt_d = sat_sum[CNT_W] ? {CNT_W{1'b1}}
                                       : sat_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_sign_q  <= '0;
            s0_mag_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_sign_q  <= '0;
            s1_mag_q   <= '0;
            sat_cnt_q  <= '0;
        end else begin
            s0_valid_q <= s0_valid_d;
            s0_sign_q  <= s0_sign_d;
            s0_mag_q   <= s0_mag_d;
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

endmodule

// File: tb/tb_psi_pipe.sv
// Directed bench for psi_pipe: vector table, streaming, backpressure,
// table write hazard, counter saturation and mid-run reset.
module tb_psi_pipe;

    localparam int W = 6;
    localparam int L = 4;

    localparam int DEF [64] = '{
        63, 55, 44, 38, 33, 30, 27, 25,
        23, 21, 19, 18, 16, 15, 14, 13,
        12, 12, 11, 10,  9,  9,  8,  8,
         7,  7,  6,  6,  6,  5,  5,  5,
         4,  4,  4,  4,  3,  3,  3,  3,
         3,  2,  2,  2,  2,  2,  2,  2,
         2,  1,  1,  1,  1,  1,  1,  1,
         1,  1,  1,  1,  1,  1,  1,  0
    };

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [L-1:0]   in_sign;
    logic [L*W-1:0] in_mag;
    logic           out_ready;
    logic           cfg_we;
    logic [W-1:0]   cfg_addr;
    logic [W-1:0]   cfg_data;
    logic           cfg_restore;
    logic           sat_clr;

    logic           in_ready, out_valid;
    logic [L-1:0]   out_sign;
    logic [L*W-1:0] out_mag;
    logic [15:0]    sat_cnt;

    logic           s_in_ready, s_out_valid;
    logic [L-1:0]   s_out_sign;
    logic [L*W-1:0] s_out_mag;
    logic [3:0]     s_sat_cnt;

    always #5 clk = ~clk;

    psi_pipe #(.WIDTH(W), .LANES(L), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_mag(out_mag),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_restore(cfg_restore),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    psi_pipe #(.WIDTH(W), .LANES(L), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_sign(in_sign), .in_mag(in_mag),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sign(s_out_sign), .out_mag(s_out_mag),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_restore(cfg_restore),
        .sat_cnt(s_sat_cnt), .sat_clr(sat_clr)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [L*W-1:0] p4(input int a, input int b,
                                          input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [L-1:0]   s;
        logic [L*W-1:0] m;
    } beat_t;

    function automatic beat_t model(input logic [L-1:0] s,
                                    input logic [L*W-1:0] m);
        beat_t r;
        r.s = s;
        r.m = '0;
        for (int l = 0; l < L; l++) begin
            r.m[l*W +: W] = 6'(DEF[m[l*W +: W]]);
        end
        return r;
    endfunction

    // Scoreboard for the streaming phases
    logic  mon_en = 1'b0;
    beat_t exp_q[$];
    beat_t hold_b;
    logic  hold_v = 1'b0;
    int    rcv = 0;
    int    cyc = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;

    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!mon_en) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) begin
                chk("hold_stable", {out_sign, out_mag}, hold_b);
            end
            hold_v = out_valid && !out_ready;
            hold_b = {out_sign, out_mag};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_sign, in_mag));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %0h want none",
                             {out_sign, out_mag});
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_beat", {out_sign, out_mag}, e);
                end
                if (rcv == 0) first_cyc = cyc;
                last_cyc = cyc;
                rcv++;
            end
        end
    end

    task automatic send_one(input string nm, input logic [L-1:0] s,
                            input logic [L*W-1:0] m,
                            input logic [L*W-1:0] e);
        in_valid = 1'b1;
        in_sign  = s;
        in_mag   = m;
        tick();
        in_valid = 1'b0;
        tick();
        chk({nm, "_valid"}, out_valid, 1'b1);
        chk({nm, "_beat"}, {out_sign, out_mag}, {s, e});
        chk({nm, "_sat_inst"}, {s_out_valid, s_out_sign, s_out_mag},
            {1'b1, s, e});
        tick();
    endtask

    typedef struct packed {
        logic [L-1:0]   sign;
        logic [L*W-1:0] mag;
        logic [L*W-1:0] exp;
        logic [2:0]     inc;
    } vec_t;

    vec_t vt [5];
    int   sat16;
    int   sat4;
    int   exp4 [5];
    int   exp16 [5];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{4'b1010, p4(0, 1, 16, 63), p4(63, 55, 12, 0), 3'd1};
        vt[1] = '{4'b0101, p4(2, 4, 8, 32), p4(44, 33, 23, 4), 3'd0};
        vt[2] = '{4'b1111, p4(48, 49, 62, 3), p4(2, 1, 1, 38), 3'd0};
        vt[3] = '{4'b0000, p4(0, 0, 0, 0), p4(63, 63, 63, 63), 3'd4};
        vt[4] = '{4'b0110, p4(17, 24, 40, 41), p4(12, 7, 3, 2), 3'd0};
        exp4  = '{4, 8, 12, 15, 15};
        exp16 = '{4, 8, 12, 16, 20};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sign = '0;
        in_mag = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_restore = 1'b0;
        sat_clr = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sign", out_sign, 4'h0);
        chk("rst_out_mag", out_mag, 24'h0);
        chk("rst_sat_cnt", sat_cnt, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        tick();

        sat16 = 0;
        for (int i = 0; i < 5; i++) begin
            send_one("vec", vt[i].sign, vt[i].mag, vt[i].exp);
            sat16 += int'(vt[i].inc);
            sat4 = (sat16 > 15) ? 15 : sat16;
            chk("vec_sat16", sat_cnt, sat16);
            chk("vec_sat4", s_sat_cnt, sat4);
            chk("vec_drained", out_valid, 1'b0);
        end

        // 64-beat stream, lane l reads address (k + 16*l) mod 64
        mon_en = 1'b1;
        rcv = 0;
        for (int k = 0; k < 64; k++) begin
            in_valid = 1'b1;
            in_sign  = 4'(k);
            in_mag   = p4(k % 64, (k + 16) % 64,
                          (k + 32) % 64, (k + 48) % 64);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick();
        tick();
        chk("stream_left", exp_q.size(), 0);
        chk("stream_count", rcv, 64);
        chk("stream_rate", last_cyc - first_cyc, 63);
        mon_en = 1'b0;
        sat16 += 4;
        chk("stream_sat", sat_cnt, sat16);

        // Backpressure: out_ready low for 5 cycles mid-stream
        mon_en = 1'b1;
        rcv = 0;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    int w;
                    in_valid = 1'b1;
                    in_sign  = 4'(k);
                    in_mag   = p4(k + 1, k + 5, k + 9, k + 13);
                    w = 0;
                    @(negedge clk);
                    while (!in_ready && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    if (w >= 50) begin
                        total++;
                        bad++;
                        $display("FAIL bp_accept: got stuck want accept");
                    end
                    @(posedge clk);
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                out_ready = 1'b0;
                repeat (3) tick();
                chk("bp_in_ready", in_ready, 1'b0);
                chk("bp_sat_in_ready", s_in_ready, 1'b0);
                chk("bp_out_valid", out_valid, 1'b1);
                repeat (2) tick();
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) tick();
        tick();
        chk("bp_left", exp_q.size(), 0);
        chk("bp_count", rcv, 12);
        mon_en = 1'b0;

        // Write to addr 16 on the same edge S1 reads it
        in_valid = 1'b1;
        in_sign  = 4'b0011;
        in_mag   = p4(16, 16, 16, 16);
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 6'd16;
        cfg_data = 6'd40;
        tick();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        chk("wr_old", out_mag, p4(12, 12, 12, 12));
        tick();
        chk("wr_new", out_mag, p4(40, 40, 40, 40));
        tick();
        cfg_we   = 1'b1;
        cfg_addr = 6'd63;
        cfg_data = 6'd17;
        tick();
        cfg_we   = 1'b0;
        send_one("wr_two", 4'b1001, p4(16, 63, 16, 63),
                 p4(40, 17, 40, 17));
        cfg_restore = 1'b1;
        cfg_we      = 1'b1;
        cfg_addr    = 6'd16;
        cfg_data    = 6'd50;
        tick();
        cfg_restore = 1'b0;
        cfg_we      = 1'b0;
        send_one("restore", 4'b0100, p4(16, 63, 5, 0),
                 p4(12, 0, 30, 63));

        // Counter saturation on the CNT_W=4 instance
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_sat16", sat_cnt, 16'd0);
        chk("clr_sat4", s_sat_cnt, 4'd0);
        for (int j = 0; j < 5; j++) begin
            send_one("sat", 4'b0000, p4(0, 0, 0, 0),
                     p4(63, 63, 63, 63));
            chk("sat_cnt16", sat_cnt, exp16[j]);
            chk("sat_cnt4", s_sat_cnt, exp4[j]);
        end
        in_valid = 1'b1;
        in_mag   = p4(0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_inc16", sat_cnt, 16'd0);
        chk("clr_inc4", s_sat_cnt, 4'd0);

        // Reset with two beats in flight and a modified table
        send_one("pre_rst", 4'b0000, p4(0, 0, 0, 0), p4(63, 63, 63, 63));
        cfg_we   = 1'b1;
        cfg_addr = 6'd16;
        cfg_data = 6'd40;
        tick();
        cfg_we    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 4'b1111;
        in_mag    = p4(16, 16, 16, 16);
        tick();
        in_mag    = p4(1, 1, 1, 1);
        tick();
        in_valid  = 1'b0;
        chk("mid_valid", out_valid, 1'b1);
        chk("mid_sat", sat_cnt, 16'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sat", sat_cnt, 16'd0);
        chk("mid_rst_sat4", s_sat_cnt, 4'd0);
        chk("mid_rst_mag", {out_sign, out_mag}, 28'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        tick();
        chk("post_rst_idle", out_valid, 1'b0);
        send_one("post_rst", 4'b0101, p4(16, 16, 1, 63),
                 p4(12, 12, 55, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
